// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the key debouncer.
// State encoding and counter sizing used by every channel.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM_PRESS,
        PRESSED,
        ARM_RELEASE
    } deb_state_t;

    function automatic int cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One key channel: 2-FF synchroniser, debounce FSM and stability counter.
// Input is already normalised so that 1 means pushed.
module debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic pressed,
    output logic busy
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    deb_state_t    state;
    deb_state_t    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Any opposite sample while arming drops back and restarts from scratch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (sync2) begin
                    state_next = ARM_PRESS;
                    cnt_next   = '0;
                end
            end
            ARM_PRESS: begin
                if (!sync2) state_next = IDLE;
                else if (cnt == LAST) state_next = PRESSED;
                else cnt_next = cnt + 1'b1;
            end
            PRESSED: begin
                if (!sync2) begin
                    state_next = ARM_RELEASE;
                    cnt_next   = '0;
                end
            end
            ARM_RELEASE: begin
                if (sync2) state_next = PRESSED;
                else if (cnt == LAST) state_next = IDLE;
                else cnt_next = cnt + 1'b1;
            end
        endcase
    end

    assign pressed = (state == PRESSED) || (state == ARM_RELEASE);
    assign busy    = (state == ARM_PRESS) || (state == ARM_RELEASE);

endmodule

// File: rtl/key_debouncer.sv
// Debounces a bank of board push-buttons into clean per-key levels.
// Polarity is normalised here; each key gets its own channel.
module key_debouncer
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] busy
);

    logic [NUM_KEYS-1:0] norm;

    assign norm = ACTIVE_LOW ? ~key_raw : key_raw;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .key    (norm[i]),
            .pressed(pressed[i]),
            .busy   (busy[i])
        );
    end

endmodule
